// File: rtl/decode_sdiv_64s_25s_40_seq.sv
// decode_sdiv_64s_25s_40_seq: iterative restoring signed divider, 64s/25s -> saturated 40s quotient; DECODE_SDIV_REM_EN adds the rem port
module decode_sdiv_64s_25s_40_seq #(
  parameter int din0_WIDTH = 64,
  parameter int din1_WIDTH = 25,
  parameter int dout_WIDTH = 40
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
`ifdef DECODE_SDIV_REM_EN
  output logic [din1_WIDTH-1:0] rem,
`endif
  output logic                  div0,
  output logic                  ovf
);
  localparam int CW = $clog2(din0_WIDTH);
  localparam logic [din0_WIDTH-1:0] QPOS = (din0_WIDTH'(1) << (dout_WIDTH - 1)) - din0_WIDTH'(1);
  localparam logic [din0_WIDTH-1:0] QNEG = din0_WIDTH'(1) << (dout_WIDTH - 1);
  localparam logic [dout_WIDTH-1:0] SMAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] SMIN = {1'b1, {(dout_WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [din0_WIDTH-1:0] dvd_q, dvd_d;
  logic [din1_WIDTH-1:0] dvs_q, dvs_d, pr_q, pr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sn_q, sn_d, sd_q, sd_d;
  logic [dout_WIDTH-1:0] dout_q, dout_d, qlo, qs;
  logic div0_q, div0_d, ovf_q, ovf_d;
  logic [din1_WIDTH:0] sh, sub;
  logic ge, neg, zero, big;
`ifdef DECODE_SDIV_REM_EN
  logic [din1_WIDTH-1:0] rem_q, rem_d;
  assign rem = rem_q;
`endif
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign dout = dout_q;
  assign div0 = div0_q;
  assign ovf  = ovf_q;
  assign sh   = {pr_q, dvd_q[din0_WIDTH-1]};
  assign sub  = sh - {1'b0, dvs_q};
  assign ge   = sh >= {1'b0, dvs_q};
  assign neg  = sn_q ^ sd_q;
  assign zero = dvs_q == '0;
  assign big  = neg ? dvd_q > QNEG : dvd_q > QPOS;
  assign qlo  = dvd_q[dout_WIDTH-1:0];
  assign qs   = neg ? -qlo : qlo;
  // next-state: capture magnitudes, one restoring step per enabled edge, then sign-fix and saturate
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    sn_d    = sn_q;
    sd_d    = sd_q;
    dout_d  = dout_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;
`ifdef DECODE_SDIV_REM_EN
    rem_d   = rem_q;
`endif
    if (ce) begin
      case (state_q)
        IDLE: if (in_valid) begin
          state_d = CALC;
          dvd_d   = din0[din0_WIDTH-1] ? -din0 : din0;
          dvs_d   = din1[din1_WIDTH-1] ? -din1 : din1;
          sn_d    = din0[din0_WIDTH-1];
          sd_d    = din1[din1_WIDTH-1];
          pr_d    = '0;
          cnt_d   = CW'(din0_WIDTH - 1);
        end
        CALC: begin
          dvd_d   = {dvd_q[din0_WIDTH-2:0], ge};
          pr_d    = ge ? sub[din1_WIDTH-1:0] : sh[din1_WIDTH-1:0];
          cnt_d   = cnt_q - CW'(1);
          state_d = cnt_q == '0 ? FIX : CALC;
        end
        FIX: begin
          dout_d  = zero ? (sn_q ? SMIN : SMAX) : big ? (neg ? SMIN : SMAX) : qs;
          div0_d  = zero;
          ovf_d   = !zero && big;
`ifdef DECODE_SDIV_REM_EN
          rem_d   = zero ? '0 : sn_q ? -pr_q : pr_q;
`endif
          state_d = DONE;
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  // state and datapath registers, cleared by the active-low synchronous reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      sn_q    <= 1'b0;
      sd_q    <= 1'b0;
      dout_q  <= '0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef DECODE_SDIV_REM_EN
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      sn_q    <= sn_d;
      sd_q    <= sd_d;
      dout_q  <= dout_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
`ifdef DECODE_SDIV_REM_EN
      rem_q   <= rem_d;
`endif
    end
  end
endmodule

// File: tb/tb_decode_sdiv_64s_25s_40_seq.sv
// tb_decode_sdiv_64s_25s_40_seq: directed scoreboard bench for the iterative signed divider
module tb_decode_sdiv_64s_25s_40_seq;
  localparam logic [39:0] QMAX = 40'h7F_FFFF_FFFF;
  localparam logic [39:0] QMIN = 40'h80_0000_0000;
  localparam logic signed [65:0] QHI = 66'sh7F_FFFF_FFFF;
  localparam logic signed [65:0] QLO = -66'sh80_0000_0000;
  typedef struct packed {logic [39:0] q; logic [24:0] r; logic z; logic o;} exp_t;
  logic clk = 1'b0, reset = 1'b0, ce = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [63:0] din0 = '0;
  logic [24:0] din1 = '0;
  logic in_ready, out_valid, div0, ovf;
  logic [39:0] dout;
`ifdef DECODE_SDIV_REM_EN
  logic [24:0] rem;
`endif
  exp_t sbq[$];
  int checks = 0, errors = 0;

  decode_sdiv_64s_25s_40_seq dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
`ifdef DECODE_SDIV_REM_EN
    .rem(rem),
`endif
    .div0(div0), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // C-semantics reference using wide signed arithmetic, then saturation
  function automatic exp_t model(input logic [63:0] a, input logic [24:0] b);
    exp_t e;
    logic signed [65:0] sa, sd, q, r;
    sa = {{2{a[63]}}, a};
    sd = {{41{b[24]}}, b};
    e = '0;
    if (b == '0) begin
      e.z = 1'b1;
      e.q = a[63] ? QMIN : QMAX;
    end else begin
      q = sa / sd;
      r = sa % sd;
      e.r = r[24:0];
      if (q > QHI) begin e.q = QMAX; e.o = 1'b1; end
      else if (q < QLO) begin e.q = QMIN; e.o = 1'b1; end
      else e.q = q[39:0];
    end
    return e;
  endfunction

  // one transaction: 65 edges after the accepting edge (66 counting it), plus any ce-low edges
  task automatic op(input logic [63:0] a, input logic [24:0] b, input int gaps, input int hold);
    exp_t e;
    int n, left, start;
    logic [39:0] held;
    sbq.push_back(model(a, b));
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    din0 = a; din1 = b; in_valid = 1'b1; out_ready = hold == 0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0; left = gaps; start = $urandom_range(3, 40);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) break;
      ce = !(left > 0 && n >= start && n % 2 == 0);
      if (!ce) left--;
    end
    ce = 1'b1;
    chk("latency", n, 65 + gaps);
    chk("in_ready_busy", in_ready, 0);
    e = sbq.pop_front();
    chk("dout", dout, e.q);
    chk("div0", div0, e.z);
    chk("ovf", ovf, e.o);
`ifdef DECODE_SDIV_REM_EN
    chk("rem", rem, e.r);
`endif
    held = dout;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; din0 = {$urandom, $urandom}; din1 = 25'd3;
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_dout", dout, held);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("consumed_valid", out_valid, 0);
    chk("consumed_in_ready", in_ready, 1);
  endtask

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_div0", div0, 0);
    chk("rst_ovf", ovf, 0);
    reset = 1'b1;
    op(64'd1000, 25'd7, 0, 0);
    // abandon a computation with reset; no result may appear afterwards
    @(negedge clk);
    din0 = 64'd1000; din1 = 25'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_dout", dout, 0);
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      seen |= int'(out_valid);
    end
    chk("abort_no_output", seen, 0);
    op(-64'sd1000, 25'd7, 0, 0);
    op(64'd1000, -25'sd7, 0, 0);
    op(64'd1 << 50, 25'd3, 0, 0);
    op(64'h8000_0000_0000_0000, -25'sd1, 0, 0);
    op(64'd5, 25'd0, 0, 0);
    op(-64'sd5, 25'd0, 0, 0);
    op(64'h7F_FFFF_FFFF, 25'd1, 0, 0);
    op(64'h80_0000_0000, 25'd1, 0, 0);
    op(-64'sh100_0000_0000, 25'd2, 0, 0);
    op(-64'sh80_0000_0001, 25'd1, 0, 0);
    op(64'd123456789012, 25'h100_0000, 0, 0);
    op(64'd77777, 25'd13, 0, 10);
    op(-64'sd999999, 25'd1234, 5, 0);
    for (int i = 0; i < 3; i++) begin
      logic [63:0] a;
      logic [24:0] b;
      a = {$urandom, $urandom};
      b = 25'($urandom);
      if (b == '0) b = 25'd1;
      op(a, b, 0, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
